// File: rtl/ysyx_24100029_wbu.sv
// ysyx_24100029_wbu: write-back stage with a single-entry holding register that commits to the register file and CSRs.
//   clock, reset             rising-edge clock, synchronous active-high reset
//   valid_last / ready_last  upstream handshake; the slot frees in the same cycle it commits
//   mem_ren, R_wen, rd, rd_value, LSU_Rdata, csr_wen, Ex_result, jump_flag  retiring instruction fields
//   stall                    holds the commit
//   rf_*, csr_*              commit-cycle write ports
//   fwd_*                    forwarding tap for the pending rd write
//   retire, retire_jump, instret  commit pulse and committed-instruction count
module ysyx_24100029_wbu #(
  parameter int CNT_W     = 64,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_last,
  output logic                 ready_last,
  input  logic                 mem_ren,
  input  logic                 R_wen,
  input  logic [RF_ADDR_W-1:0] rd,
  input  logic [31:0]          rd_value,
  input  logic [31:0]          LSU_Rdata,
  input  logic [3:0]           csr_wen,
  input  logic [31:0]          Ex_result,
  input  logic                 jump_flag,
  input  logic                 stall,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [3:0]           csr_we,
  output logic [31:0]          csr_wdata,
  output logic                 fwd_valid,
  output logic [RF_ADDR_W-1:0] fwd_rd,
  output logic [31:0]          fwd_data,
  output logic                 retire,
  output logic                 retire_jump,
  output logic [CNT_W-1:0]     instret
);
  logic                 full, r_wen_q, jump_q, com, acc, rd_nz;
  logic [RF_ADDR_W-1:0] rd_q;
  logic [31:0]          wdata_q, csr_data_q;
  logic [3:0]           csr_wen_q;
  // a pending instruction caught by reset is dropped, never committed
  assign com         = full & ~stall & ~reset;
  assign ready_last  = ~full | com;
  assign acc         = valid_last & ready_last;
  assign rd_nz       = rd_q != '0;
  assign rf_wen      = com & r_wen_q & rd_nz;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = wdata_q;
  assign csr_we      = com ? csr_wen_q : 4'b0;
  assign csr_wdata   = csr_data_q;
  assign fwd_valid   = full & r_wen_q & rd_nz;
  assign fwd_rd      = rd_q;
  assign fwd_data    = wdata_q;
  assign retire      = com;
  assign retire_jump = com & jump_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      full       <= 1'b0;
      r_wen_q    <= 1'b0;
      jump_q     <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      csr_wen_q  <= '0;
      csr_data_q <= '0;
      instret    <= '0;
    end else begin
      full <= acc | (full & ~com);
      if (acc) begin
        r_wen_q    <= R_wen;
        jump_q     <= jump_flag;
        rd_q       <= rd;
        wdata_q    <= mem_ren ? LSU_Rdata : rd_value;
        csr_wen_q  <= csr_wen;
        csr_data_q <= Ex_result;
      end
      if (com) instret <= instret + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// tb_ysyx_24100029_wbu: directed scoreboard bench for the write-back stage.
module tb_ysyx_24100029_wbu;
  logic        clock = 1'b0, reset = 1'b1;
  logic        valid_last = 1'b0, mem_ren = 1'b0, R_wen = 1'b0, jump_flag = 1'b0, stall = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] rd_value = '0, LSU_Rdata = '0, Ex_result = '0;
  logic [3:0]  csr_wen = '0;
  logic        ready_last, rf_wen, fwd_valid, retire, retire_jump;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, csr_wdata, fwd_data;
  logic [3:0]  csr_we;
  logic [63:0] instret;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [3:0]  csr;
    logic [31:0] cdata;
    logic        jmp;
  } ent_t;

  ent_t        sb[$];
  ent_t        h, e;
  int          tests = 0, fails = 0;
  logic [63:0] exp_instret = '0;
  logic        exp_ready, exp_com;

  ysyx_24100029_wbu dut (
    .clock(clock), .reset(reset), .valid_last(valid_last), .ready_last(ready_last),
    .mem_ren(mem_ren), .R_wen(R_wen), .rd(rd), .rd_value(rd_value), .LSU_Rdata(LSU_Rdata),
    .csr_wen(csr_wen), .Ex_result(Ex_result), .jump_flag(jump_flag), .stall(stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire), .retire_jump(retire_jump), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic mr, input logic w, input logic [4:0] r,
                       input logic [31:0] val, input logic [31:0] lsu, input logic [3:0] c,
                       input logic [31:0] ex, input logic j);
    valid_last = v; mem_ren = mr; R_wen = w; rd = r; rd_value = val;
    LSU_Rdata = lsu; csr_wen = c; Ex_result = ex; jump_flag = j;
  endtask

  // inputs are already driven; check at the falling edge, update the model, then cross the rising edge
  task automatic tick();
    @(negedge clock);
    exp_ready = (sb.size() == 0) || !stall;
    exp_com   = (sb.size() != 0) && !stall;
    chk("ready_last", 64'(ready_last), 64'(exp_ready));
    chk("retire", 64'(retire), 64'(exp_com));
    chk("instret", instret, exp_instret);
    if (sb.size() != 0) begin
      h = sb[0];
      chk("fwd_valid", 64'(fwd_valid), 64'(h.wen));
      if (h.wen) begin
        chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
        chk("fwd_data", 64'(fwd_data), 64'(h.wdata));
      end
    end else chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
    if (exp_com) begin
      e = sb.pop_front();
      chk("rf_wen", 64'(rf_wen), 64'(e.wen));
      if (e.wen) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
      end
      chk("csr_we", 64'(csr_we), 64'(e.csr));
      if (e.csr != 0) chk("csr_wdata", 64'(csr_wdata), 64'(e.cdata));
      chk("retire_jump", 64'(retire_jump), 64'(e.jmp));
      exp_instret++;
    end else begin
      chk("rf_wen_idle", 64'(rf_wen), 64'd0);
      chk("csr_we_idle", 64'(csr_we), 64'd0);
      chk("retire_jump_idle", 64'(retire_jump), 64'd0);
    end
    if (valid_last && exp_ready)
      sb.push_back('{wen: R_wen && rd != 0, rd: rd, wdata: mem_ren ? LSU_Rdata : rd_value,
                     csr: csr_wen, cdata: Ex_result, jmp: jump_flag});
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    chk("retire_in_reset", 64'(retire), 64'd0);
    chk("rf_wen_in_reset", 64'(rf_wen), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    exp_instret = '0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    @(negedge clock);
    chk("rst_ready", 64'(ready_last), 64'd1);
    chk("rst_instret", instret, 64'd0);
    chk("rst_outs", {rf_wen, rf_waddr, csr_we, fwd_valid, fwd_rd, retire, retire_jump}, 64'd0);
    chk("rst_data", {rf_wdata, csr_wdata}, 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    @(posedge clock); #1;
    // simple ALU write to x5
    drive(1, 0, 1, 5, 32'h1234, 32'hDEAD, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    tick();
    chk("instret_after_first", instret, 64'd1);
    // load selects LSU data over rd_value
    drive(1, 1, 1, 3, 32'h7, 32'hFFFFFF80, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    // rd=0 retires without writing or forwarding
    drive(1, 0, 1, 0, 32'h55, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    // stall for three cycles with a second instruction waiting upstream
    drive(1, 0, 1, 7, 32'hCAFE0007, 0, 0, 0, 0); tick();
    stall = 1'b1;
    drive(1, 0, 1, 9, 32'hBEEF0009, 0, 0, 0, 1);
    tick(); tick(); tick();
    stall = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    tick();
    // ten back-to-back instructions, one of them a CSR write
    for (int i = 0; i < 10; i++) begin
      if (i == 4) drive(1, 0, 0, 0, 0, 0, 4'b0010, 32'h8000_0000, 0);
      else drive(1, 1'($urandom_range(0, 1)), 1, 5'($urandom_range(1, 31)), $urandom, $urandom,
                 0, $urandom, 1'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    tick();
    chk("instret_total", instret, 64'd15);
    // multi-bit CSR write
    drive(1, 0, 0, 0, 0, 0, 4'b1001, 32'h1357_9BDF, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    // reset while full and stalled drops the instruction
    drive(1, 0, 1, 12, 32'hABCD, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b1;
    tick();
    do_reset();
    stall = 1'b0;
    tick();
    chk("instret_after_reset", instret, 64'd0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
